dual_rail_tx: RTL and testbench

DUAL_RAIL_TX -- requirements
Module: dual_rail_tx

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/ack_sync.sv | 33 +++
 rtl/dual_rail_tx.sv | 167 ++++++++++++++++
 tb/tb_dual_rail_tx.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the asynchronous CPU link.
//                - instruction_code : 4-bit opcode carried in word[7:4]
//                - register_code    : 2-bit register selectors in word[3:2]
//                                     and word[1:0]
//                - DR_SPACER        : all-zero dual-rail spacer codeword
//                - dr_encode        : 8-bit word to 16-bit dual-rail codeword
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [3:0] {
        NOP   = 4'h0,
        LOAD  = 4'h1,
        STORE = 4'h2,
        JUMP  = 4'h3,
        ADD   = 4'hC,
        SUB   = 4'hD
    } instruction_code;

    typedef enum logic [1:0] {
        REG_A = 2'd0,
        REG_B = 2'd1,
        REG_C = 2'd2,
        REG_D = 2'd3
    } register_code;

    localparam logic [15:0] DR_SPACER = 16'h0000;

    // Bit i of the word maps to pair {[2i+1], [2i]}: true rail high for a 1,
    // false rail high for a 0. A pair can therefore never be 11.
    function automatic logic [15:0] dr_encode(input logic [7:0] word);
        logic [15:0] code;
        code = DR_SPACER;
        for (int i = 0; i < 8; i++) begin
            code[2*i+1] = word[i];
            code[2*i]   = ~word[i];
        end
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ack_sync.sv
`default_nettype none
// ============================================================================
//  Module      : ack_sync
//  Description : Multi-flop synchronizer for the asynchronous four-phase ack.
//  Ports       : clk     - clock
//                rst     - synchronous active-high reset, clears all flops
//                i_async - asynchronous input
//                o_sync  - synchronized output (SYNC_STAGES edges of latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module ack_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/dual_rail_tx.sv
`default_nettype none
// ============================================================================
//  Module      : dual_rail_tx
//  Description : Single-rail to dual-rail four-phase transmitter. Accepts an
//                8-bit word with a valid/ready handshake and presents it to an
//                asynchronous receiver as a 16-bit dual-rail codeword,
//                returning to the all-zero spacer between words.
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous active-high reset
//                in_valid   - single-rail word valid
//                in_data    - single-rail word (opcode[7:4], fields[3:0])
//                in_ready   - word accepted this cycle when high with in_valid
//                dr_data    - dual-rail codeword / spacer to receiver
//                dr_ack     - four-phase ack from receiver (asynchronous)
//                sent_count - completed word count, wraps 255 -> 0
//                err        - sticky ack timeout flag
//  Options     : DR_TX_TIMEOUT_EN - when defined, any non-IDLE state held for
//                TIMEOUT_CYCLES cycles sets err and returns to IDLE; when
//                undefined, err is constant 0 and the block waits forever.
//  Revision    : 1.0 - initial release
// ============================================================================
module dual_rail_tx
    import cpu_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [15:0] dr_data,
    input  logic        dr_ack,
    output logic [7:0]  sent_count,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_LO = 2'd1,
        DATA    = 2'd2,
        RTZ     = 2'd3
    } state_t;

    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("dual_rail_tx: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    state_t      r_state;
    state_t      w_state_next;
    logic        r_in_ready;
    logic [15:0] r_dr_data;
    logic [7:0]  r_sent_count;
    logic [7:0]  r_word;

    logic        w_ack_s;
    logic        w_handshake;
    logic        w_timeout;
    logic        w_in_ready_nxt;
    logic [15:0] w_dr_data_nxt;
    logic [7:0]  w_sent_count_nxt;
    logic [7:0]  w_word_nxt;

    ack_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (dr_ack),
        .o_sync  (w_ack_s)
    );

    assign w_handshake = in_valid & r_in_ready;

`ifdef DR_TX_TIMEOUT_EN
    localparam int                  c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0]  c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               r_err;

    // Counts cycles spent in the current waiting state; restarts on every
    // state change so each handshake phase gets the full budget.
    assign w_timeout = (r_state != IDLE) && (r_tmo_cnt == c_TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_state_next != r_state) begin
                r_tmo_cnt <= '0;
            end else if (r_state != IDLE) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    // State register; all outputs are registered alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_in_ready   <= 1'b1;
            r_dr_data    <= DR_SPACER;
            r_sent_count <= 8'd0;
            r_word       <= 8'd0;
        end else begin
            r_state      <= w_state_next;
            r_in_ready   <= w_in_ready_nxt;
            r_dr_data    <= w_dr_data_nxt;
            r_sent_count <= w_sent_count_nxt;
            r_word       <= w_word_nxt;
        end
    end

    // Next-state logic. WAIT_LO and RTZ only look for ack low, so a stray ack
    // high in those states simply keeps them waiting.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_handshake) w_state_next = WAIT_LO;
            WAIT_LO: if (!w_ack_s)    w_state_next = DATA;
            DATA:    if (w_ack_s)     w_state_next = RTZ;
            RTZ:     if (!w_ack_s)    w_state_next = IDLE;
            default:                  w_state_next = IDLE;
        endcase
        if (w_timeout) begin
            w_state_next = IDLE;
        end
    end

    // Output logic. The codeword is only launched from a cycle already spent
    // in DATA and only while DATA persists, so leaving DATA (ack or timeout)
    // drops straight to spacer on the same edge, and the output register only
    // ever toggles between spacer and a complete codeword.
    always_comb begin
        w_in_ready_nxt   = (w_state_next == IDLE);
        w_dr_data_nxt    = DR_SPACER;
        w_sent_count_nxt = r_sent_count;
        w_word_nxt       = r_word;
        if ((r_state == DATA) && (w_state_next == DATA)) begin
            w_dr_data_nxt = dr_encode(r_word);
        end
        if ((r_state == DATA) && (w_state_next == RTZ)) begin
            w_sent_count_nxt = r_sent_count + 8'd1;
        end
        if ((r_state == IDLE) && w_handshake) begin
            w_word_nxt = in_data;
        end
    end

    assign in_ready   = r_in_ready;
    assign dr_data    = r_dr_data;
    assign sent_count = r_sent_count;

endmodule
`default_nettype wire

// File: tb/tb_dual_rail_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dual_rail_tx
//  Description : Self-checking bench for dual_rail_tx. Random words and random
//                receiver latencies are checked against a behavioural model of
//                the dual-rail code and the completion count.
//  Options     : DR_TX_TIMEOUT_EN selects the timeout scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_rail_tx;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [15:0] dr_data;
    logic        dr_ack;
    logic [7:0]  sent_count;
    logic        err;

    int          total;
    int          bad;
    logic [7:0]  exp_count;
    logic [7:0]  cur_word;
    logic [15:0] last_cw;
    logic        mon_en;

    dual_rail_tx #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .dr_data    (dr_data),
        .dr_ack     (dr_ack),
        .sent_count (sent_count),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference dual-rail code: each bit becomes "10" for 1, "01" for 0,
    // most significant bit in the most significant pair.
    function automatic logic [15:0] model_dr(input logic [7:0] w);
        logic [15:0] r;
        r = 16'h0;
        for (int i = 7; i >= 0; i--) begin
            r = (r << 2) | (w[i] ? 16'd2 : 16'd1);
        end
        return r;
    endfunction

    // Continuous invariant: no pair 11, and only spacer or the full current word.
    always @(negedge clk) begin
        if (mon_en) begin
            logic pair11;
            pair11 = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (dr_data[2*i+1] === 1'b1 && dr_data[2*i] === 1'b1) pair11 = 1'b1;
            end
            total++;
            if (pair11 || !(dr_data === 16'h0 || dr_data === model_dr(cur_word))) begin
                bad++;
                $display("FAIL monitor_codeword: dr_data=%h required spacer or %h", dr_data, model_dr(cur_word));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        dr_ack   = 1'b0;
        repeat (3) step();
        rst       = 1'b0;
        exp_count = 8'd0;
        cur_word  = 8'd0;
        mon_en    = 1'b1;
    endtask

    // One complete four-phase transfer with a well-behaved receiver.
    task automatic xfer(input logic [7:0] w, input int ack_lat, input int rel_lat);
        int t;
        in_data  = w;
        in_valid = 1'b1;
        t = 0;
        while (in_ready !== 1'b1 && t < 100) begin step(); t++; end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL xfer_ready: in_ready=%b required 1", in_ready);
        end
        step();
        cur_word = w;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        t = 0;
        while (dr_data === 16'h0 && t < 50) begin step(); t++; end
        last_cw = dr_data;
        total++;
        if (dr_data !== model_dr(w)) begin
            bad++;
            $display("FAIL xfer_codeword: dr_data=%h required %h", dr_data, model_dr(w));
        end
        repeat (ack_lat) step();
        dr_ack = 1'b1;
        t = 0;
        while (dr_data !== 16'h0 && t < 50) begin step(); t++; end
        exp_count = exp_count + 8'd1;
        total++;
        if (dr_data !== 16'h0 || sent_count !== exp_count) begin
            bad++;
            $display("FAIL xfer_complete: dr_data=%h sent_count=%0d required 0000 and %0d",
                     dr_data, sent_count, exp_count);
        end
        repeat (rel_lat) step();
        dr_ack = 1'b0;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin step(); t++; end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL xfer_return_idle: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (in_ready !== 1'b1 || dr_data !== 16'h0 || sent_count !== 8'd0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: ready=%b dr=%h cnt=%0d err=%b required 1 0000 0 0",
                     in_ready, dr_data, sent_count, err);
        end
    endtask

    task automatic test_basic();
        int t;
        in_data  = 8'b1100_0110;
        in_valid = 1'b1;
        step();                         // edge N accepts
        cur_word = 8'b1100_0110;
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0 || dr_data !== 16'h0) begin
            bad++;
            $display("FAIL basic_edge_n: ready=%b dr=%h required 0 0000", in_ready, dr_data);
        end
        step();                         // edge N+1
        total++;
        if (dr_data !== 16'h0) begin
            bad++;
            $display("FAIL basic_edge_n1: dr=%h required 0000", dr_data);
        end
        step();                         // edge N+2
        total++;
        if (dr_data !== 16'b1010_0101_0110_1001) begin
            bad++;
            $display("FAIL basic_edge_n2: dr=%h required a569", dr_data);
        end
        dr_ack = 1'b1;
        t = 0;
        while (dr_data !== 16'h0 && t < 20) begin step(); t++; end
        exp_count = 8'd1;
        total++;
        if (dr_data !== 16'h0 || sent_count !== 8'd1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_ack_high: dr=%h cnt=%0d ready=%b required 0000 1 0",
                     dr_data, sent_count, in_ready);
        end
        dr_ack = 1'b0;
        t = 0;
        while (in_ready !== 1'b1 && t < 20) begin step(); t++; end
        total++;
        if (in_ready !== 1'b1 || sent_count !== 8'd1) begin
            bad++;
            $display("FAIL basic_idle: ready=%b cnt=%0d required 1 1", in_ready, sent_count);
        end
    endtask

    task automatic test_extremes();
        xfer(8'h00, 1, 1);
        total++;
        if (last_cw !== 16'h5555) begin
            bad++;
            $display("FAIL extreme_00: dr=%h required 5555", last_cw);
        end
        xfer(8'hFF, 2, 0);
        total++;
        if (last_cw !== 16'hAAAA) begin
            bad++;
            $display("FAIL extreme_ff: dr=%h required aaaa", last_cw);
        end
    endtask

    task automatic test_ack_held();
        int t;
        dr_ack = 1'b1;
        repeat (3) step();
        in_data  = 8'h5A;
        in_valid = 1'b1;
        step();
        cur_word = 8'h5A;
        in_valid = 1'b0;
        repeat (10) step();
        total++;
        if (dr_data !== 16'h0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL ack_held_wait: dr=%h ready=%b required 0000 0", dr_data, in_ready);
        end
        dr_ack = 1'b0;
        t = 0;
        while (dr_data === 16'h0 && t < 20) begin step(); t++; end
        total++;
        if (dr_data !== model_dr(8'h5A)) begin
            bad++;
            $display("FAIL ack_held_codeword: dr=%h required %h", dr_data, model_dr(8'h5A));
        end
        dr_ack = 1'b1;
        t = 0;
        while (dr_data !== 16'h0 && t < 20) begin step(); t++; end
        exp_count = exp_count + 8'd1;
        dr_ack = 1'b0;
        t = 0;
        while (in_ready !== 1'b1 && t < 20) begin step(); t++; end
        total++;
        if (sent_count !== exp_count || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ack_held_done: cnt=%0d ready=%b required %0d 1", sent_count, in_ready, exp_count);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) step();
            xfer(8'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
        end
    endtask

    task automatic test_reset_mid_data();
        apply_reset();
        in_data  = 8'h96;
        in_valid = 1'b1;
        step();
        cur_word = 8'h96;
        in_valid = 1'b0;
        repeat (2) step();
        total++;
        if (dr_data !== model_dr(8'h96)) begin
            bad++;
            $display("FAIL rst_mid_codeword: dr=%h required %h", dr_data, model_dr(8'h96));
        end
        rst = 1'b1;
        step();
        total++;
        if (dr_data !== 16'h0 || sent_count !== 8'd0) begin
            bad++;
            $display("FAIL rst_mid_drop: dr=%h cnt=%0d required 0000 0", dr_data, sent_count);
        end
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_ready: ready=%b required 1", in_ready);
        end
        step();
        total++;
        if (in_ready !== 1'b1 || dr_data !== 16'h0 || sent_count !== 8'd0) begin
            bad++;
            $display("FAIL rst_mid_after: ready=%b dr=%h cnt=%0d required 1 0000 0",
                     in_ready, dr_data, sent_count);
        end
    endtask

`ifdef DR_TX_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        in_data  = 8'h3C;
        in_valid = 1'b1;
        step();                         // edge N
        cur_word = 8'h3C;
        in_valid = 1'b0;
        repeat (2) step();              // edge N+2, DATA entered at N+1
        repeat (6) step();              // edge N+8: 7 cycles in DATA
        total++;
        if (err !== 1'b0 || dr_data !== model_dr(8'h3C)) begin
            bad++;
            $display("FAIL timeout_early: err=%b dr=%h required 0 %h", err, dr_data, model_dr(8'h3C));
        end
        step();                         // edge N+9: 8 cycles in DATA
        total++;
        if (err !== 1'b1 || dr_data !== 16'h0 || in_ready !== 1'b1 || sent_count !== 8'd0) begin
            bad++;
            $display("FAIL timeout_fire: err=%b dr=%h ready=%b cnt=%0d required 1 0000 1 0",
                     err, dr_data, in_ready, sent_count);
        end
        repeat (5) step();
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky: err=%b required 1", err);
        end
        apply_reset();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_clear: err=%b required 0", err);
        end
    endtask
`else
    task automatic test_wait_forever();
        int t;
        apply_reset();
        in_data  = 8'h3C;
        in_valid = 1'b1;
        step();
        cur_word = 8'h3C;
        in_valid = 1'b0;
        repeat (40) step();
        total++;
        if (err !== 1'b0 || dr_data !== model_dr(8'h3C) || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL wait_forever: err=%b dr=%h ready=%b required 0 %h 0",
                     err, dr_data, in_ready, model_dr(8'h3C));
        end
        dr_ack = 1'b1;
        t = 0;
        while (dr_data !== 16'h0 && t < 20) begin step(); t++; end
        dr_ack = 1'b0;
        t = 0;
        while (in_ready !== 1'b1 && t < 20) begin step(); t++; end
        total++;
        if (sent_count !== 8'd1 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL wait_forever_done: cnt=%0d ready=%b required 1 1", sent_count, in_ready);
        end
    endtask
`endif

    task automatic test_wrap();
        apply_reset();
        for (int n = 0; n < 256; n++) begin
            xfer(8'($urandom), 0, 0);
        end
        total++;
        if (sent_count !== 8'd0) begin
            bad++;
            $display("FAIL wrap_256: cnt=%0d required 0", sent_count);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        mon_en   = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        dr_ack   = 1'b0;
        exp_count = 8'd0;
        cur_word = 8'd0;
        last_cw  = 16'h0;

        test_reset();
        test_basic();
        test_extremes();
        test_ack_held();
        test_random();
        test_reset_mid_data();
`ifdef DR_TX_TIMEOUT_EN
        test_timeout();
`else
        test_wait_forever();
`endif
        test_wrap();

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
